// File: rtl/reg_wb_ctrl.sv
// rtl/reg_wb_ctrl.sv - in-order writeback FIFO feeding the register file write port
// Define WB_BYPASS_EN to build the queued-result bypass lookup ports; otherwise they read as zero.
module reg_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [4:0]                 a_rd,
    input  logic [XLEN-1:0]            a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [4:0]                 b_rd,
    input  logic [XLEN-1:0]            b_data,
    output logic                       rf_we,
    output logic [4:0]                 rf_rd_addr,
    output logic [XLEN-1:0]            rf_rd_data,
    input  logic [4:0]                 q1_addr,
    output logic                       q1_hit,
    output logic [XLEN-1:0]            q1_data,
    input  logic [4:0]                 q2_addr,
    output logic                       q2_hit,
    output logic [XLEN-1:0]            q2_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [4:0]      ent_rd   [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];
    logic            a_push;
    logic            b_push;
    logic            pop;

    // Writes to x0 are acknowledged but dropped, so they never take a slot.
    assign a_ready = count < DEPTH_C;
    assign a_push  = a_valid && a_ready && (a_rd != 5'd0);
    assign b_ready = (count + CW'(a_push)) < DEPTH_C;
    assign b_push  = b_valid && b_ready && (b_rd != 5'd0);

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign pop   = !empty;

    assign rf_we      = pop;
    assign rf_rd_addr = pop ? ent_rd[rd_ptr]   : 5'd0;
    assign rf_rd_data = pop ? ent_data[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(a_push) + PW'(b_push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(a_push) + CW'(b_push) - CW'(pop);
        end
    end

    // A is older than B when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (a_push) begin
            ent_rd[wr_ptr]   <= a_rd;
            ent_data[wr_ptr] <= a_data;
        end
        if (b_push) begin
            ent_rd[wr_ptr + PW'(a_push)]   <= b_rd;
            ent_data[wr_ptr + PW'(a_push)] <= b_data;
        end
    end

`ifdef WB_BYPASS_EN
    logic [PW-1:0] scan_idx;

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        q1_hit   = 1'b0;
        q1_data  = '0;
        q2_hit   = 1'b0;
        q2_data  = '0;
        scan_idx = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if ((q1_addr != 5'd0) && (ent_rd[scan_idx] == q1_addr)) begin
                    q1_hit  = 1'b1;
                    q1_data = ent_data[scan_idx];
                end
                if ((q2_addr != 5'd0) && (ent_rd[scan_idx] == q2_addr)) begin
                    q2_hit  = 1'b1;
                    q2_data = ent_data[scan_idx];
                end
            end
        end
    end
`else
    logic unused_q;

    assign q1_hit   = 1'b0;
    assign q1_data  = '0;
    assign q2_hit   = 1'b0;
    assign q2_data  = '0;
    assign unused_q = ^{q1_addr, q2_addr};
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb/tb_reg_wb_ctrl.sv - directed self-checking bench for reg_wb_ctrl
module tb_reg_wb_ctrl;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            a_valid, a_ready, b_valid, b_ready;
    logic [4:0]      a_rd, b_rd, rf_rd_addr, q1_addr, q2_addr;
    logic [XLEN-1:0] a_data, b_data, rf_rd_data, q1_data, q2_data;
    logic            rf_we, q1_hit, q2_hit, full, empty;
    logic [2:0]      count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [36:0] mq[$];

    reg_wb_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .q1_addr(q1_addr), .q1_hit(q1_hit), .q1_data(q1_data),
        .q2_addr(q2_addr), .q2_hit(q2_hit), .q2_data(q2_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_a(input logic v, input logic [4:0] rd, input logic [31:0] d);
        a_valid = v;
        a_rd    = rd;
        a_data  = d;
    endtask

    task automatic set_b(input logic v, input logic [4:0] rd, input logic [31:0] d);
        b_valid = v;
        b_rd    = rd;
        b_data  = d;
    endtask

    // Entered at posedge+1 with inputs driven; checks against the queue model, then crosses one edge.
    task automatic tick();
        bit ea, eas, eb, ebs;
        #2;
        ea  = mq.size() < DEPTH;
        eas = a_valid && ea && (a_rd != 5'd0);
        eb  = (mq.size() + int'(eas)) < DEPTH;
        ebs = b_valid && eb && (b_rd != 5'd0);
        check("a_ready", a_ready, ea);
        check("b_ready", b_ready, eb);
        check("rf_we", rf_we, mq.size() != 0);
        check("count", count, mq.size());
        if (mq.size() != 0) begin
            check("rf_rd_addr", rf_rd_addr, mq[0][36:32]);
            check("rf_rd_data", rf_rd_data, mq[0][31:0]);
        end
        @(posedge clk);
        if (mq.size() != 0) void'(mq.pop_front());
        if (eas) mq.push_back({a_rd, a_data});
        if (ebs) mq.push_back({b_rd, b_data});
        #1;
    endtask

    initial begin
        set_a(0, 0, 0);
        set_b(0, 0, 0);
        q1_addr = 0;
        q2_addr = 0;
        #2;
        check("rst_we", rf_we, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_addr", rf_rd_addr, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single A result
        set_a(1, 5, 32'hDEADBEEF);
        tick();
        set_a(0, 0, 0);
        #1;
        check("t2_we", rf_we, 1);
        check("t2_addr", rf_rd_addr, 5);
        check("t2_data", rf_rd_data, 32'hDEADBEEF);
        tick();
        #1 check("t2_idle_we", rf_we, 0);
        tick();

        // A and B same cycle, same rd: A written first, bypass sees youngest
        set_a(1, 3, 32'h11);
        set_b(1, 3, 32'h22);
        tick();
        set_a(0, 0, 0);
        set_b(0, 0, 0);
        q1_addr = 3;
        #1;
        check("t3_first", rf_rd_data, 32'h11);
        check("t3_q1_hit", q1_hit, BYP);
        check("t3_q1_data", q1_data, BYP ? 32'h22 : 32'h0);
        tick();
        #1 check("t3_second", rf_rd_data, 32'h22);
        tick();
        tick();

        // rd = 0 accepted but dropped
        q1_addr = 0;
        set_a(1, 0, 32'h55);
        #1 check("t4_a_ready", a_ready, 1);
        tick();
        set_a(0, 0, 0);
        #1;
        check("t4_count", count, 0);
        check("t4_we", rf_we, 0);
        check("t4_q1_hit", q1_hit, 0);
        tick();

        // fill to 3, then both valid: B back-pressured
        set_a(1, 1, 32'hA1);
        set_b(1, 2, 32'hB2);
        tick();
        set_a(1, 3, 32'hA3);
        set_b(1, 4, 32'hB4);
        tick();
        set_a(1, 5, 32'hA5);
        set_b(1, 6, 32'hB6);
        #1;
        check("t5_count3", count, 3);
        check("t5_a_ready", a_ready, 1);
        check("t5_b_ready", b_ready, 0);
        tick();
        #1 check("t5_count_hold", count, 3);

        // sustained traffic across several pointer wraps
        for (int i = 0; i < 14; i++) begin
            set_a((i % 3) != 2, 5'(1 + i % 7), 32'hA000 + i);
            set_b(1'b1, 5'(20 + i % 5), 32'hB000 + i);
            tick();
        end
        set_a(0, 0, 0);
        set_b(0, 0, 0);
        repeat (5) tick();
        check("t5_drained", empty, 1);

        // bypass lookup port 2
        set_a(1, 7, 32'h77);
        tick();
        set_a(0, 0, 0);
        q2_addr = 7;
        #1;
        check("t6_q2_hit", q2_hit, BYP);
        check("t6_q2_data", q2_data, BYP ? 32'h77 : 32'h0);
        tick();
        #1 check("t6_q2_after", q2_hit, 0);
        q2_addr = 0;

        // reset mid-operation with 3 queued
        set_a(1, 9, 32'h99);
        set_b(1, 10, 32'hAA);
        tick();
        set_a(1, 11, 32'hBB);
        set_b(1, 12, 32'hCC);
        tick();
        set_a(0, 0, 0);
        set_b(0, 0, 0);
        #1 check("t1_pre_count", count, 3);
        #1 rst_n = 1'b0;
        #1;
        check("t1_rst_we", rf_we, 0);
        check("t1_rst_count", count, 0);
        check("t1_rst_empty", empty, 1);
        check("t1_rst_addr", rf_rd_addr, 0);
        check("t1_rst_data", rf_rd_data, 0);
        mq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
